// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Shares the register file's single write port between two writeback
//   requesters: A (ALU result) and B (load/memory result). The requesters are
//   arbitrated round-robin. The winning write is registered onto the regfile
//   write port (wen1/ad1/din1), so it appears one cycle after acceptance.
//   A per-register pending-write scoreboard is also kept, so that issue logic
//   can stall on the two regfile read addresses.
//
// Parameters:
//   ADDR_WIDTH  register address width (the scoreboard has 2**ADDR_WIDTH bits)
//   DATA_WIDTH  write data width
//
// Ports:
//   clk                 single clock; all state updates on posedge
//   rst                 synchronous, active-high reset
//   issue_valid         an instruction writing issue_rd issues this cycle
//   issue_rd            destination register of the issued instruction
//   a_valid/a_rd/a_data requester A write request
//   a_ready             A's write is accepted this cycle
//   b_valid/b_rd/b_data requester B write request
//   b_ready             B's write is accepted this cycle
//   rf_wen/rf_ad/rf_din regfile write port (wen1/ad1/din1)
//   chk_ad2/chk_ad3     regfile read addresses ad2/ad3, mirrored here
//   busy2/busy3         the matching read address has an outstanding write
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,

    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ADDR_WIDTH-1:0] a_rd,
    input  logic [DATA_WIDTH-1:0] a_data,

    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] b_rd,
    input  logic [DATA_WIDTH-1:0] b_data,

    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_ad,
    output logic [DATA_WIDTH-1:0] rf_din,

    input  logic [ADDR_WIDTH-1:0] chk_ad2,
    input  logic [ADDR_WIDTH-1:0] chk_ad3,
    output logic                  busy2,
    output logic                  busy3
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    // Round-robin pointer: names the side that wins when both are valid.
    localparam logic PTR_A = 1'b0;
    localparam logic PTR_B = 1'b1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic                  r_ptr;
    logic                  r_wen;
    logic [ADDR_WIDTH-1:0] r_ad;
    logic [DATA_WIDTH-1:0] r_din;
    logic [NUM_REGS-1:0]   r_sb;

    // -------------------------------------------------------------------------
    // Combinational grant
    // -------------------------------------------------------------------------
    logic                  w_grant_a;
    logic                  w_grant_b;
    logic [NUM_REGS-1:0]   w_sb_next;

    // A lone requester always wins; under contention the pointer side wins.
    // Reset suppresses both grants so nothing is accepted in a reset cycle.
    assign w_grant_a = !rst && a_valid && (!b_valid || (r_ptr == PTR_A));
    assign w_grant_b = !rst && b_valid && (!a_valid || (r_ptr == PTR_B));

    assign a_ready = w_grant_a;
    assign b_ready = w_grant_b;

    // -------------------------------------------------------------------------
    // Round-robin pointer
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= PTR_A;
        end else if (w_grant_a) begin
            r_ptr <= PTR_B;
        end else if (w_grant_b) begin
            r_ptr <= PTR_A;
        end
    end

    // -------------------------------------------------------------------------
    // Registered regfile write port (latency 1 from acceptance)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen <= 1'b0;
            r_ad  <= '0;
            r_din <= '0;
        end else if (w_grant_a) begin
            r_wen <= 1'b1;
            r_ad  <= a_rd;
            r_din <= a_data;
        end else if (w_grant_b) begin
            r_wen <= 1'b1;
            r_ad  <= b_rd;
            r_din <= b_data;
        end else begin
            // Address/data hold their last values; only the enable drops.
            r_wen <= 1'b0;
        end
    end

    assign rf_wen = r_wen;
    assign rf_ad  = r_ad;
    assign rf_din = r_din;

    // -------------------------------------------------------------------------
    // Pending-write scoreboard
    // -------------------------------------------------------------------------
    // The clear is applied first and the set second, so when both hit the same
    // register the set wins: a newer producer is still outstanding.
    always_comb begin
        // NOTE: the next-state vector gets a full default before any partial
        // update; without it this block would infer latches.
        w_sb_next = r_sb;
        if (r_wen) begin
            w_sb_next[r_ad] = 1'b0;
        end
        if (issue_valid) begin
            w_sb_next[issue_rd] = 1'b1;
        end
    end

    // NOTE: the scoreboard is a flop vector, not a RAM, so it can and must be
    // cleared by reset; stale pending bits would stall issue forever.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb <= '0;
        end else begin
            r_sb <= w_sb_next;
        end
    end

    // No forwarding: busy reflects the registered scoreboard only.
    assign busy2 = r_sb[chk_ad2];
    assign busy3 = r_sb[chk_ad3];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          issue_valid;
    logic [AW-1:0] issue_rd;
    logic          a_valid;
    logic          a_ready;
    logic [AW-1:0] a_rd;
    logic [DW-1:0] a_data;
    logic          b_valid;
    logic          b_ready;
    logic [AW-1:0] b_rd;
    logic [DW-1:0] b_data;
    logic          rf_wen;
    logic [AW-1:0] rf_ad;
    logic [DW-1:0] rf_din;
    logic [AW-1:0] chk_ad2;
    logic [AW-1:0] chk_ad3;
    logic          busy2;
    logic          busy3;

    regfile_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_rd       (a_rd),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_rd       (b_rd),
        .b_data     (b_data),
        .rf_wen     (rf_wen),
        .rf_ad      (rf_ad),
        .rf_din     (rf_din),
        .chk_ad2    (chk_ad2),
        .chk_ad3    (chk_ad3),
        .busy2      (busy2),
        .busy3      (busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          a_valid;
        logic [AW-1:0] a_rd;
        logic [DW-1:0] a_data;
        logic          b_valid;
        logic [AW-1:0] b_rd;
        logic [DW-1:0] b_data;
        logic          issue_valid;
        logic [AW-1:0] issue_rd;
        logic [AW-1:0] chk2;
        logic [AW-1:0] chk3;
        logic          exp_a_ready;
        logic          exp_b_ready;
        logic          exp_busy2;
        logic          exp_busy3;
    } vec_t;

    typedef struct {
        logic          wen;
        logic [AW-1:0] ad;
        logic [DW-1:0] din;
    } wr_t;

    wr_t           exp_q[$];
    logic [AW-1:0] m_ad;
    logic [DW-1:0] m_din;
    int            n_cmp  = 0;
    int            n_fail = 0;
    vec_t          vecs[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
        input logic bv, input logic [AW-1:0] brd, input logic [DW-1:0] bd,
        input logic iv, input logic [AW-1:0] ird,
        input logic [AW-1:0] c2, input logic [AW-1:0] c3,
        input logic ea, input logic eb, input logic e2, input logic e3);
        vec_t v;
        v.a_valid = av; v.a_rd = ard; v.a_data = ad;
        v.b_valid = bv; v.b_rd = brd; v.b_data = bd;
        v.issue_valid = iv; v.issue_rd = ird;
        v.chk2 = c2; v.chk3 = c3;
        v.exp_a_ready = ea; v.exp_b_ready = eb;
        v.exp_busy2 = e2; v.exp_busy3 = e3;
        return v;
    endfunction

    // One clock cycle: drive inputs, check combinational outputs, push the
    // expected write-port state, clock, then pop and compare the write port.
    task automatic apply(input vec_t v, input logic rst_v);
        wr_t e;
        wr_t g;
        rst         = rst_v;
        a_valid     = v.a_valid;  a_rd = v.a_rd;  a_data = v.a_data;
        b_valid     = v.b_valid;  b_rd = v.b_rd;  b_data = v.b_data;
        issue_valid = v.issue_valid;
        issue_rd    = v.issue_rd;
        chk_ad2     = v.chk2;
        chk_ad3     = v.chk3;
        #1;
        check("a_ready", a_ready, v.exp_a_ready);
        check("b_ready", b_ready, v.exp_b_ready);
        check("busy2", busy2, v.exp_busy2);
        check("busy3", busy3, v.exp_busy3);
        if (rst_v) begin
            m_ad = '0; m_din = '0;
            e.wen = 1'b0;
        end else if (v.exp_a_ready) begin
            m_ad = v.a_rd; m_din = v.a_data;
            e.wen = 1'b1;
        end else if (v.exp_b_ready) begin
            m_ad = v.b_rd; m_din = v.b_data;
            e.wen = 1'b1;
        end else begin
            e.wen = 1'b0;
        end
        e.ad  = m_ad;
        e.din = m_din;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 1'b1, 1'b0);
        end else begin
            g = exp_q.pop_front();
            check("rf_wen", rf_wen, g.wen);
            check("rf_ad", rf_ad, g.ad);
            check("rf_din", rf_din, g.din);
        end
    endtask

    initial begin
        vec_t v;
        rst = 1'b1;
        issue_valid = 1'b0; issue_rd = '0;
        a_valid = 1'b0; a_rd = '0; a_data = '0;
        b_valid = 1'b0; b_rd = '0; b_data = '0;
        chk_ad2 = '0; chk_ad3 = '0;
        m_ad = '0; m_din = '0;

        // Plain reset.
        @(posedge clk);
        #1;
        check("reset_rf_wen", rf_wen, 1'b0);
        check("reset_rf_ad", rf_ad, '0);
        check("reset_rf_din", rf_din, '0);
        check("reset_busy2", busy2, 1'b0);
        check("reset_busy3", busy3, 1'b0);

        // Reset dominates valids and issue: no grant, no scoreboard set.
        apply(mk(1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 1, 5'd6, 5'd6, 5'd6, 0, 0, 0, 0), 1'b1);

        // Table: A(ALU) / B(load) traffic, contention, scoreboard set/clear.
        vecs.push_back(mk(1, 5'd12, 32'hC,        1, 5'd13, 32'hD,  0, 5'd0,  5'd6, 5'd0,  1, 0, 0, 0)); // first contention -> A
        vecs.push_back(mk(1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,  0, 5'd0,  5'd5, 5'd0,  1, 0, 0, 0)); // single A
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  0, 5'd0,  5'd5, 5'd0,  0, 0, 0, 0)); // write to sb=0 reg
        vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd4,  32'h44, 0, 5'd0,  5'd5, 5'd0,  0, 1, 0, 0)); // single B
        vecs.push_back(mk(1, 5'd1,  32'h11,       1, 5'd2,  32'h22, 0, 5'd0,  5'd0, 5'd0,  1, 0, 0, 0)); // contention A
        vecs.push_back(mk(1, 5'd1,  32'h11,       1, 5'd2,  32'h22, 0, 5'd0,  5'd0, 5'd0,  0, 1, 0, 0)); //            B
        vecs.push_back(mk(1, 5'd1,  32'h11,       1, 5'd2,  32'h22, 0, 5'd0,  5'd0, 5'd0,  1, 0, 0, 0)); //            A
        vecs.push_back(mk(1, 5'd1,  32'h11,       1, 5'd2,  32'h22, 0, 5'd0,  5'd0, 5'd0,  0, 1, 0, 0)); //            B
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  1, 5'd7,  5'd7, 5'd0,  0, 0, 0, 0)); // issue rd7
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  0, 5'd0,  5'd7, 5'd0,  0, 0, 1, 0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  0, 5'd0,  5'd7, 5'd0,  0, 0, 1, 0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd7,  32'h77, 0, 5'd0,  5'd7, 5'd0,  0, 1, 1, 0)); // B writes rd7
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  0, 5'd0,  5'd7, 5'd0,  0, 0, 1, 0)); // rf_wen ad7
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  0, 5'd0,  5'd7, 5'd0,  0, 0, 0, 0)); // busy2 drops
        vecs.push_back(mk(1, 5'd9,  32'h99,       0, 5'd0,  32'h0,  0, 5'd0,  5'd0, 5'd9,  1, 0, 0, 0)); // A writes rd9
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  1, 5'd9,  5'd0, 5'd9,  0, 0, 0, 0)); // set+clear rd9
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  0, 5'd0,  5'd0, 5'd9,  0, 0, 0, 1)); // set won
        vecs.push_back(mk(1, 5'd9,  32'hAA,       0, 5'd0,  32'h0,  0, 5'd0,  5'd0, 5'd9,  1, 0, 0, 1)); // A writes rd9
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  1, 5'd10, 5'd9, 5'd10, 0, 0, 1, 0)); // clear 9, set 10
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  0, 5'd0,  5'd9, 5'd10, 0, 0, 0, 1)); // both applied
        vecs.push_back(mk(1, 5'd11, 32'hB1,       1, 5'd10, 32'hBB, 0, 5'd0,  5'd0, 5'd10, 0, 1, 0, 1)); // ptr at B
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  0, 5'd0,  5'd0, 5'd10, 0, 0, 0, 1));
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  0, 5'd0,  5'd0, 5'd10, 0, 0, 0, 0));
        foreach (vecs[i]) begin
            apply(vecs[i], 1'b0);
        end

        // Reset mid-write: A accepted with rd3 pending in the scoreboard,
        // then rst while both requesters are still presenting.
        apply(mk(1, 5'd3, 32'h33, 0, 5'd0, 32'h0, 1, 5'd3, 5'd3, 5'd0, 1, 0, 0, 0), 1'b0);
        apply(mk(1, 5'd3, 32'h34, 1, 5'd8, 32'h88, 0, 5'd0, 5'd3, 5'd0, 0, 0, 1, 0), 1'b1);
        apply(mk(0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 5'd0, 5'd3, 5'd7, 0, 0, 0, 0), 1'b0);

        // Every scoreboard entry is clear after the mid-operation reset.
        v = mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        for (int i = 0; i < (1 << AW); i++) begin
            chk_ad2 = AW'(i);
            chk_ad3 = AW'((1 << AW) - 1 - i);
            #1;
            check("sb_clear_busy2", busy2, 1'b0);
            check("sb_clear_busy3", busy3, 1'b0);
        end

        // Requesters re-present after reset: pointer is back at A.
        apply(mk(1, 5'd3, 32'h35, 1, 5'd8, 32'h88, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0), 1'b0);
        apply(v, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
